// File: rtl/generador_ventana_pkg.sv
// Shared constants and FSM encoding for the cross-shaped window generator.
package generador_ventana_pkg;
  localparam int PIX_W     = 8;
  localparam int ANCHO_DEF = 8;
  localparam int ALTO_DEF  = 8;

  typedef enum logic [1:0] {
    LLENADO   = 2'd0,
    CORRIENDO = 2'd1,
    VACIADO   = 2'd2
  } estado_t;
endpackage

// File: rtl/generador_ventana_linea_retardo.sv
// Shift-enabled pixel delay line; entry 0 holds the newest pixel.
module linea_retardo
  import generador_ventana_pkg::*;
#(
  parameter int LARGO = 2*ANCHO_DEF+1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [PIX_W-1:0]             din,
  output logic [LARGO-1:0][PIX_W-1:0]  taps
);
  logic [LARGO-1:0][PIX_W-1:0] r_linea;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_linea <= '0;
    end else if (en) begin
      r_linea <= {r_linea[LARGO-2:0], din};
    end
  end

  assign taps = r_linea;
endmodule

// File: rtl/generador_ventana.sv
// Streams raster pixels into a 2-row delay line and emits zero-padded cross windows.
//   state     | meaning
//   LLENADO   | priming the delay line with the first row, no windows
//   CORRIENDO | one window per accepted pixel
//   VACIADO   | input stalled, zeros shifted in to emit the last row
module generador_ventana
  import generador_ventana_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF,
  parameter int ALTO  = ALTO_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [PIX_W-1:0] A,
  output logic [PIX_W-1:0] B,
  output logic [PIX_W-1:0] C,
  output logic [PIX_W-1:0] D,
  output logic [PIX_W-1:0] E,
  output logic             win_valid,
  output logic             fin_cuadro
);
  localparam int LARGO  = 2*ANCHO+1;
  localparam int COL_W  = $clog2(ANCHO);
  localparam int FILA_W = $clog2(ALTO);
  localparam logic [COL_W-1:0]  COL_ULT  = COL_W'(ANCHO-1);
  localparam logic [FILA_W-1:0] FILA_ULT = FILA_W'(ALTO-1);
  localparam logic [FILA_W-1:0] FILA_PEN = FILA_W'(ALTO-2);

  estado_t                     r_estado, w_estado_sig;
  logic [COL_W-1:0]            r_col, r_cnt_llenado;
  logic [FILA_W-1:0]           r_fila;
  logic                        w_acepta, w_desplaza, w_emite, w_ultimo;
  logic [PIX_W-1:0]            w_din;
  logic [LARGO-1:0][PIX_W-1:0] w_taps;
  logic                        w_unused_taps;

  linea_retardo #(.LARGO(LARGO)) u_linea (
    .clk  (clk),
    .rst  (rst),
    .en   (w_desplaza),
    .din  (w_din),
    .taps (w_taps)
  );

  // Only the cross taps feed the window; the rest of the line is pure storage.
  assign w_unused_taps = ^w_taps;

  always_ff @(posedge clk) begin
    if (rst) r_estado <= LLENADO;
    else     r_estado <= w_estado_sig;
  end

  always_comb begin
    w_estado_sig = r_estado;
    pix_ready    = 1'b1;
    w_acepta     = 1'b0;
    w_desplaza   = 1'b0;
    w_emite      = 1'b0;
    w_ultimo     = 1'b0;
    w_din        = pix_in;
    case (r_estado)
      LLENADO: begin
        w_acepta   = pix_valid;
        w_desplaza = pix_valid;
        if (pix_valid && r_cnt_llenado == '0) w_estado_sig = CORRIENDO;
      end
      CORRIENDO: begin
        w_acepta   = pix_valid;
        w_desplaza = pix_valid;
        w_emite    = pix_valid;
        if (pix_valid && r_fila == FILA_PEN && r_col == COL_ULT) w_estado_sig = VACIADO;
      end
      VACIADO: begin
        pix_ready  = 1'b0;
        w_din      = '0;
        w_desplaza = 1'b1;
        w_emite    = 1'b1;
        w_ultimo   = (r_col == COL_ULT);
        if (r_col == COL_ULT) w_estado_sig = LLENADO;
      end
      default: w_estado_sig = LLENADO;
    endcase
  end

  // Taps are read one entry below their post-shift position so the registered
  // window reflects the line as it stands after this edge's shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      A             <= '0;
      B             <= '0;
      C             <= '0;
      D             <= '0;
      E             <= '0;
      win_valid     <= 1'b0;
      fin_cuadro    <= 1'b0;
      r_fila        <= '0;
      r_col         <= '0;
      r_cnt_llenado <= COL_ULT;
    end else begin
      win_valid  <= w_emite;
      fin_cuadro <= w_ultimo;
      if (r_estado == LLENADO && w_acepta) begin
        r_cnt_llenado <= (r_cnt_llenado == '0) ? COL_ULT : r_cnt_llenado - COL_W'(1);
      end
      if (w_emite) begin
        A <= w_taps[ANCHO-1];
        B <= (r_fila == '0)       ? '0 : w_taps[2*ANCHO-1];
        C <= (r_fila == FILA_ULT) ? '0 : w_din;
        D <= (r_col == '0)        ? '0 : w_taps[ANCHO];
        E <= (r_col == COL_ULT)   ? '0 : w_taps[ANCHO-2];
        if (r_col == COL_ULT) begin
          r_col  <= '0;
          r_fila <= w_ultimo ? '0 : r_fila + FILA_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_generador_ventana.sv
// Directed bench for generador_ventana on a 4x4 frame whose pixel k has value k+1.
module tb_generador_ventana;
  localparam int AN = 4;
  localparam int AL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pix_in = '0;
  logic       pix_valid = 1'b0;
  logic       pix_ready;
  logic [7:0] A, B, C, D, E;
  logic       win_valid, fin_cuadro;

  int total = 0;
  int bad   = 0;
  int n_win = 0;
  int n_fin = 0;
  int idx   = 0;
  int mr, mc, n0;
  logic ok_prev = 1'b0;

  generador_ventana #(.ANCHO(AN), .ALTO(AL)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .A          (A),
    .B          (B),
    .C          (C),
    .D          (D),
    .E          (E),
    .win_valid  (win_valid),
    .fin_cuadro (fin_cuadro)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Frame value at (r,c); anything off the image is the zero pad.
  function automatic int px(input int r, input int c);
    if (r < 0 || r >= AL || c < 0 || c >= AN) return 0;
    return r*AN + c + 1;
  endfunction

  task automatic send_pix(input logic [7:0] v);
    int t;
    t = 0;
    pix_in = v;
    pix_valid = 1'b1;
    while (!pix_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) begin
      total++;
      bad++;
      $error("FAIL send_timeout observed=%0d expected=%0d", t, 0);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!pix_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) begin
      total++;
      bad++;
      $error("FAIL ready_timeout observed=%0d expected=%0d", t, 0);
    end
  endtask

  // Every window is checked in order against the frame model.
  always @(negedge clk) begin
    if (win_valid) begin
      mr = idx / AN;
      mc = idx % AN;
      chk("win_after_accept", ok_prev, 1);
      chk("win_A", A, px(mr, mc));
      chk("win_B", B, px(mr-1, mc));
      chk("win_C", C, px(mr+1, mc));
      chk("win_D", D, px(mr, mc-1));
      chk("win_E", E, px(mr, mc+1));
      chk("win_fin", fin_cuadro, idx == AN*AL-1);
      n_win++;
      idx = (idx == AN*AL-1) ? 0 : idx + 1;
    end
    if (fin_cuadro) n_fin++;
    if (rst) begin
      idx = 0;
      ok_prev = 1'b0;
    end else begin
      ok_prev = (pix_valid && pix_ready) || !pix_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_C", C, 0);
    chk("rst_D", D, 0);
    chk("rst_E", E, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_fin", fin_cuadro, 0);
    chk("rst_pix_ready", pix_ready, 1);
    rst = 1'b0;

    // Continuous frame
    n_win = 0; n_fin = 0;
    for (int k = 1; k <= 4; k++) send_pix(8'(k));
    chk("fill_no_window", win_valid, 0);
    send_pix(8'd5);
    chk("first_valid", win_valid, 1);
    chk("first_A", A, 1);
    chk("first_B", B, 0);
    chk("first_C", C, 5);
    chk("first_D", D, 0);
    chk("first_E", E, 2);
    for (int k = 6; k <= 10; k++) send_pix(8'(k));
    chk("int_A", A, 6);
    chk("int_B", B, 2);
    chk("int_C", C, 10);
    chk("int_D", D, 5);
    chk("int_E", E, 7);
    for (int k = 11; k <= 16; k++) send_pix(8'(k));
    n0 = 0;
    while (!pix_ready && n0 < 20) begin
      n0++;
      @(posedge clk); #1;
    end
    chk("flush_cycles", n0, 4);
    chk("last_valid", win_valid, 1);
    chk("last_fin", fin_cuadro, 1);
    chk("last_A", A, 16);
    chk("last_B", B, 12);
    chk("last_C", C, 0);
    chk("last_D", D, 15);
    chk("last_E", E, 0);
    chk("ready_after_flush", pix_ready, 1);
    idle(1);
    chk("fin_one_cycle", fin_cuadro, 0);
    chk("valid_drops", win_valid, 0);
    idle(2);
    chk("frame_windows", n_win, 16);
    chk("frame_fins", n_fin, 1);

    // Back-pressure: one idle cycle after every pixel
    n_win = 0; n_fin = 0;
    for (int k = 1; k <= 16; k++) begin
      send_pix(8'(k));
      idle(1);
      if (k < 16) chk("bp_gap_no_window", win_valid, 0);
    end
    wait_ready();
    idle(3);
    chk("bp_windows", n_win, 16);
    chk("bp_fins", n_fin, 1);

    // Reset after pixel 9, with pix_valid high during reset
    n_win = 0; n_fin = 0;
    for (int k = 1; k <= 9; k++) send_pix(8'(k));
    rst = 1'b1;
    pix_valid = 1'b1;
    pix_in = 8'hAA;
    @(posedge clk); #1;
    rst = 1'b0;
    pix_valid = 1'b0;
    chk("rst_mid_valid", win_valid, 0);
    chk("rst_mid_A", A, 0);
    chk("rst_mid_ready", pix_ready, 1);
    idle(6);
    chk("rst_mid_windows", n_win, 5);
    chk("rst_mid_fins", n_fin, 0);
    n_win = 0; n_fin = 0;
    for (int k = 1; k <= 4; k++) send_pix(8'(k));
    send_pix(8'd5);
    chk("rst_first_valid", win_valid, 1);
    chk("rst_first_A", A, 1);
    chk("rst_first_B", B, 0);
    chk("rst_first_C", C, 5);
    chk("rst_first_D", D, 0);
    chk("rst_first_E", E, 2);
    for (int k = 6; k <= 16; k++) send_pix(8'(k));
    wait_ready();
    idle(2);
    chk("rst_frame_windows", n_win, 16);
    chk("rst_frame_fins", n_fin, 1);

    // Two frames back to back
    n_win = 0; n_fin = 0;
    for (int f = 0; f < 2; f++) begin
      for (int k = 1; k <= 16; k++) send_pix(8'(k));
    end
    wait_ready();
    idle(2);
    chk("b2b_windows", n_win, 32);
    chk("b2b_fins", n_fin, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/generador_ventana.md
GENERADOR_VENTANA -- requirements
Module: generador_ventana

Interface
REQ-001 SHALL have parameter ANCHO, default 8: image width in pixels, at least 3.
REQ-002 SHALL have parameter ALTO, default 8: image height in pixels, at least 3.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port pix_in, input, 8 bits: raster-order pixel, row 0 first, column 0 first.
REQ-006 SHALL have port pix_valid, input, 1 bit: pix_in is valid; a pixel is accepted when pix_valid=1 and pix_ready=1.
REQ-007 SHALL have port pix_ready, output, 1 bit: block can accept a pixel this cycle.
REQ-008 SHALL have ports A, B, C, D, E, output, 8 bits each: cross window = center, up, down, left, right; these drive the downstream maximum comparator directly.
REQ-009 SHALL have port win_valid, output, 1 bit: A..E hold a valid window this cycle.
REQ-010 SHALL have port fin_cuadro, output, 1 bit: one-cycle pulse together with the last window of a frame.

Function
REQ-011 SHALL keep a delay line of 2*ANCHO+1 pixels that shifts only on an accepted pixel or a flush cycle; newest entry index 0.
REQ-012 SHALL take the taps as: down = entry 0, right = entry ANCHO-1, center = entry ANCHO, left = entry ANCHO+1, up = entry 2*ANCHO.
REQ-013 SHALL track the center coordinate (fila, col), starting at (0,0) each frame; col wraps at ANCHO-1 and increments fila.
REQ-014 SHALL zero-pad: B=0 when fila=0; C=0 when fila=ALTO-1; D=0 when col=0; E=0 when col=ANCHO-1. Zero is neutral for a maximum.
REQ-015 SHALL implement FSM LLENADO -> CORRIENDO -> VACIADO -> LLENADO.
REQ-016 LLENADO: pix_ready=1; accepted pixels shift in with no window output; after ANCHO accepted pixels, go to CORRIENDO.
REQ-017 CORRIENDO: pix_ready=1; each accepted pixel produces one registered window, with win_valid=1 on the next cycle; after the frame's ALTO*ANCHO-th accepted pixel, go to VACIADO.
REQ-018 VACIADO: pix_ready=0; shift zero in for exactly ANCHO cycles, each cycle producing one window; the last of these asserts fin_cuadro; then go to LLENADO with fila=col=0.
REQ-019 SHALL emit exactly ALTO*ANCHO windows per frame, in raster order of the center pixel.
REQ-020 SHALL hold state and outputs, with win_valid=0 the cycle after, when pix_valid=0 in LLENADO/CORRIENDO; gaps of any length are allowed.
REQ-021 SHALL ignore pix_in/pix_valid entirely while in VACIADO.
REQ-022 SHALL give A..E the latency of one cycle from the accepting (or flush) edge, registered.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, set state=LLENADO, fila=col=0, all delay-line entries=0, and A..E=0, win_valid=0, fin_cuadro=0, pix_ready=1 from the next cycle.
REQ-024 SHALL let rst mid-frame, including during VACIADO, abandon the frame; no further windows from it; the next accepted pixel is treated as pixel (0,0).
REQ-025 SHALL give rst priority over a simultaneous pix_valid.

Structure
REQ-026 SHALL place in a shared package: pixel width 8, ANCHO/ALTO defaults, and FSM state encoding (LLENADO, CORRIENDO, VACIADO).
REQ-027 SHALL put the shift-enabled delay line in sub-module linea_retardo (parameter LARGO = 2*ANCHO+1, ports clk, rst, en, din, parallel taps out).

Verification (ANCHO=ALTO=4, frame pixel k = k+1, k=0..15, pix_valid held 1 unless stated)
REQ-028 SHALL verify first window: A=1, B=0, C=5, D=0, E=2, win_valid=1 the cycle after the 5th pixel is accepted.
REQ-029 SHALL verify interior center (1,1): A=6, B=2, C=10, D=5, E=7.
REQ-030 SHALL verify flush: pix_ready=0 for exactly 4 cycles after pixel 16 is accepted; last window A=16, B=12, C=0, D=15, E=0 with fin_cuadro=1; 16 windows in total; pix_ready=1 afterwards.
REQ-031 SHALL verify back-pressure: pix_valid toggled 1/0 every cycle yields the same 16 windows in the same order, with win_valid only after accepting cycles.
REQ-032 SHALL verify reset: rst asserted after pixel 9 causes no further windows; a new frame sent afterwards gives a first window of A=1, B=0, C=5, D=0, E=2.
REQ-033 SHALL verify back-to-back: two frames sent consecutively give 32 windows and exactly two fin_cuadro pulses.
